// File: rtl/spectro_pkg.sv
// Shared types and default geometry for the spectrogram readout link.
// Used by both the transmitter and the host-side receiver.
package spectro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BINS,
    TRAIL
  } rx_state_t;

  localparam int WORD_W_DEF     = 8;
  localparam int N_BINS_DEF     = 16;
  localparam int TS_W_DEF       = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/readout_word_fifo.sv
// Synchronous word FIFO with first-word fall-through head.
// A push into a full FIFO is accepted only when a pop frees the slot.
module readout_word_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_rd;
  logic         do_wr;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/spectrogram_readout_receiver.sv
// Host-side receiver for the 2-bit spectrogram readout stream.
// Deframes timestamp + bin words and queues words in a small FIFO.
module spectrogram_readout_receiver
  import spectro_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int N_BINS     = N_BINS_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      input_serial_readout_clk,
  input  logic                      reset,
  input  logic [1:0]                serial_in,
  input  logic                      sending_data,
  input  logic                      sl_ch_in,
  input  logic                      err_clr,
  output logic [TS_W-1:0]           ts_out,
  output logic                      ts_valid,
  output logic                      ch_out,
  output logic [WORD_W-1:0]         word_data,
  output logic [$clog2(N_BINS)-1:0] word_index,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      err_truncated,
  output logic                      err_overrun,
  output logic                      err_overflow
);

  localparam int IDX_W = $clog2(N_BINS);
  localparam int SR_W  = max_i(TS_W, WORD_W);
  localparam int CNT_W = (SR_W / 2 > 2) ? $clog2(SR_W / 2) : 1;
  localparam int FW    = WORD_W + IDX_W;

  localparam logic [CNT_W-1:0] TS_LAST = CNT_W'(TS_W / 2 - 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WORD_W / 2 - 1);
  localparam logic [IDX_W-1:0] B_LAST  = IDX_W'(N_BINS - 1);

  rx_state_t        state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic             ch_q, ch_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             tsv_q, tsv_d;
  logic             fd_q, fd_d;
  logic             etr_q, etr_d;
  logic             eor_q, eor_d;
  logic             eof_q, eof_d;

  logic             push;
  logic             ev_trunc;
  logic             ev_over;
  logic             ff_full;
  logic             ff_empty;
  logic [FW-1:0]    ff_head;

  assign sr_sh = {sr_q[SR_W-3:0], serial_in};

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    ch_d     = ch_q;
    ts_d     = ts_q;
    tsv_d    = 1'b0;
    fd_d     = 1'b0;
    push     = 1'b0;
    ev_trunc = 1'b0;
    ev_over  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sending_data) begin
          sr_d    = sr_sh;
          ch_d    = sl_ch_in;
          cnt_d   = CNT_W'(1);
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (!sending_data) begin
          ev_trunc = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          sr_d = sr_sh;
          if (cnt_q == TS_LAST) begin
            ts_d    = sr_sh[TS_W-1:0];
            tsv_d   = 1'b1;
            cnt_d   = '0;
            bin_d   = '0;
            state_d = BINS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BINS: begin
        if (!sending_data) begin
          ev_trunc = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          sr_d = sr_sh;
          if (cnt_q == WD_LAST) begin
            push  = 1'b1;
            cnt_d = '0;
            bin_d = bin_q + 1'b1;
            if (bin_q == B_LAST) begin
              fd_d    = 1'b1;
              state_d = TRAIL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRAIL: begin
        if (sending_data) ev_over = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error events override a simultaneous clear.
  always_comb begin
    etr_d = (etr_q & ~err_clr) | ev_trunc;
    eor_d = (eor_q & ~err_clr) | ev_over;
    eof_d = (eof_q & ~err_clr) | (push & ff_full & ~word_ready);
  end

  always_ff @(posedge input_serial_readout_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ch_q    <= 1'b0;
      ts_q    <= '0;
      tsv_q   <= 1'b0;
      fd_q    <= 1'b0;
      etr_q   <= 1'b0;
      eor_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ch_q    <= ch_d;
      ts_q    <= ts_d;
      tsv_q   <= tsv_d;
      fd_q    <= fd_d;
      etr_q   <= etr_d;
      eor_q   <= eor_d;
      eof_q   <= eof_d;
    end
  end

  readout_word_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (input_serial_readout_clk),
    .rst_i     (reset),
    .wr_en_i   (push),
    .wr_data_i ({bin_q, sr_sh[WORD_W-1:0]}),
    .rd_en_i   (word_ready),
    .rd_data_o (ff_head),
    .full_o    (ff_full),
    .empty_o   (ff_empty)
  );

  assign ts_out        = ts_q;
  assign ts_valid      = tsv_q;
  assign ch_out        = ch_q;
  assign word_data     = ff_head[WORD_W-1:0];
  assign word_index    = ff_head[FW-1:WORD_W];
  assign word_valid    = ~ff_empty;
  assign frame_done    = fd_q;
  assign busy          = (state_q == HEADER) || (state_q == BINS);
  assign err_truncated = etr_q;
  assign err_overrun   = eor_q;
  assign err_overflow  = eof_q;

endmodule

// File: tb/tb_spectrogram_readout_receiver.sv
// Directed bench for the readout receiver (8-bit words, 4 bins, 8-bit ts).
// Table of clean frames plus hand sequences for the error corners.
module tb_spectrogram_readout_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] serial_in;
  logic       sending_data;
  logic       sl_ch_in;
  logic       err_clr;
  logic [7:0] ts_out;
  logic       ts_valid;
  logic       ch_out;
  logic [7:0] word_data;
  logic [1:0] word_index;
  logic       word_valid;
  logic       word_ready;
  logic       frame_done;
  logic       busy;
  logic       err_truncated;
  logic       err_overrun;
  logic       err_overflow;

  always #5 clk = ~clk;

  spectrogram_readout_receiver #(
    .WORD_W     (8),
    .N_BINS     (4),
    .TS_W       (8),
    .FIFO_DEPTH (4)
  ) dut (
    .input_serial_readout_clk (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .sending_data  (sending_data),
    .sl_ch_in      (sl_ch_in),
    .err_clr       (err_clr),
    .ts_out        (ts_out),
    .ts_valid      (ts_valid),
    .ch_out        (ch_out),
    .word_data     (word_data),
    .word_index    (word_index),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .frame_done    (frame_done),
    .busy          (busy),
    .err_truncated (err_truncated),
    .err_overrun   (err_overrun),
    .err_overflow  (err_overflow)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ts_cnt  = 0;
  int         fd_cnt  = 0;
  logic [9:0] got[$];

  always @(negedge clk) begin
    if (ts_valid) ts_cnt <= ts_cnt + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (word_valid && word_ready) got.push_back({word_index, word_data});
  end

  typedef struct {
    logic [7:0] ts;
    logic [7:0] b[4];
    logic       ch;
    logic [7:0] exp_ts;
    logic [7:0] exp_w[4];
    logic       exp_ch;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_pairs(input logic [39:0] bits, input int n, input logic ch);
    for (int j = 0; j < n; j++) begin
      serial_in    = bits[39-2*j -: 2];
      sending_data = 1'b1;
      sl_ch_in     = ch;
      tick();
    end
    sending_data = 1'b0;
    serial_in    = 2'b00;
  endtask

  function automatic logic [39:0] fbits(input vec_t v);
    return {v.ts, v.b[0], v.b[1], v.b[2], v.b[3]};
  endfunction

  task automatic chk_words(input string nm, input int base, input vec_t v);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got.size())
        chk(nm, {22'd0, got[base+i]}, {22'd0, 2'(i), v.exp_w[i]});
      else
        chk({nm, "_missing"}, 32'(got.size()), 32'(base + i + 1));
    end
  endtask

  task automatic clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  int b0, t0, f0;

  initial begin
    vt[0] = '{ts:8'hA5, b:'{8'h12, 8'h34, 8'h56, 8'h78}, ch:1'b0,
              exp_ts:8'hA5, exp_w:'{8'h12, 8'h34, 8'h56, 8'h78}, exp_ch:1'b0};
    vt[1] = '{ts:8'h3C, b:'{8'h00, 8'hFF, 8'h81, 8'h7E}, ch:1'b1,
              exp_ts:8'h3C, exp_w:'{8'h00, 8'hFF, 8'h81, 8'h7E}, exp_ch:1'b1};
    vt[2] = '{ts:8'hFF, b:'{8'h01, 8'h80, 8'hAA, 8'h55}, ch:1'b0,
              exp_ts:8'hFF, exp_w:'{8'h01, 8'h80, 8'hAA, 8'h55}, exp_ch:1'b0};

    reset = 1'b1; serial_in = 2'b00; sending_data = 1'b0;
    sl_ch_in = 1'b0; err_clr = 1'b0; word_ready = 1'b1;
    idle(3);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_ts_out", ts_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_truncated, err_overrun, err_overflow}, 0);
    chk("rst_word_data", word_data, 0);
    reset = 1'b0;
    idle(1);

    // Clean frames, ready held high.
    for (int k = 0; k < 3; k++) begin
      b0 = got.size(); t0 = ts_cnt; f0 = fd_cnt;
      send_pairs(fbits(vt[k]), 20, vt[k].ch);
      idle(4);
      chk("tbl_ts_out", ts_out, vt[k].exp_ts);
      chk("tbl_ch_out", ch_out, vt[k].exp_ch);
      chk("tbl_ts_valid_cnt", ts_cnt - t0, 1);
      chk("tbl_frame_done_cnt", fd_cnt - f0, 1);
      chk("tbl_word_cnt", got.size() - b0, 4);
      chk_words("tbl_word", b0, vt[k]);
      chk("tbl_errs", {err_truncated, err_overrun, err_overflow}, 0);
    end

    // Ready low: latency and hold, then drain in order.
    word_ready = 1'b0;
    b0 = got.size(); f0 = fd_cnt;
    for (int j = 0; j < 20; j++) begin
      serial_in = fbits(vt[0])[39-2*j -: 2];
      sending_data = 1'b1;
      tick();
      if (j == 2) chk("hold_ts_valid_early", ts_valid, 0);
      if (j == 3) chk("hold_ts_valid", ts_valid, 1);
      if (j == 4) chk("hold_ts_valid_pulse", ts_valid, 0);
      if (j == 6) chk("hold_wv_early", word_valid, 0);
      if (j == 7) chk("hold_wv_latency", {word_valid, word_index, word_data}, {1'b1, 2'd0, 8'h12});
    end
    sending_data = 1'b0;
    idle(2);
    chk("hold_head", {word_valid, word_index, word_data}, {1'b1, 2'd0, 8'h12});
    chk("hold_no_overflow", err_overflow, 0);
    chk("hold_frame_done", fd_cnt - f0, 1);
    word_ready = 1'b1;
    idle(6);
    chk("hold_drain_cnt", got.size() - b0, 4);
    chk_words("hold_drain", b0, vt[0]);

    // Two frames into a stalled FIFO.
    word_ready = 1'b0;
    b0 = got.size(); f0 = fd_cnt;
    send_pairs(fbits(vt[0]), 20, 1'b0);
    tick();
    send_pairs(fbits(vt[1]), 20, 1'b1);
    idle(2);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_frame_done", fd_cnt - f0, 2);
    chk("ovf_ts_out", ts_out, 8'h3C);
    word_ready = 1'b1;
    idle(6);
    chk("ovf_drain_cnt", got.size() - b0, 4);
    chk_words("ovf_drain", b0, vt[0]);
    clr();
    chk("ovf_clr", err_overflow, 0);

    // Truncation mid-BINS after bin 0 completes.
    word_ready = 1'b0;
    b0 = got.size(); f0 = fd_cnt;
    send_pairs(fbits(vt[0]), 10, 1'b0);
    tick();
    chk("trunc_flag", err_truncated, 1);
    chk("trunc_busy", busy, 0);
    chk("trunc_head", {word_valid, word_index, word_data}, {1'b1, 2'd0, 8'h12});
    word_ready = 1'b1;
    idle(3);
    chk("trunc_words", got.size() - b0, 1);
    chk("trunc_no_fd", fd_cnt - f0, 0);
    clr();
    t0 = ts_cnt;
    send_pairs(fbits(vt[1]), 2, 1'b1);
    idle(2);
    chk("trunc_hdr_flag", err_truncated, 1);
    chk("trunc_hdr_no_tsv", ts_cnt - t0, 0);
    chk("trunc_hdr_ts_kept", ts_out, 8'hA5);
    clr();
    b0 = got.size();
    send_pairs(fbits(vt[2]), 20, 1'b0);
    idle(4);
    chk("trunc_next_ts", ts_out, 8'hFF);
    chk_words("trunc_next", b0, vt[2]);
    chk("trunc_next_errs", {err_truncated, err_overrun, err_overflow}, 0);

    // Overrun: envelope held 3 cycles past the frame.
    b0 = got.size();
    send_pairs(fbits(vt[1]), 20, 1'b1);
    sending_data = 1'b1;
    idle(3);
    chk("ovr_flag", err_overrun, 1);
    err_clr = 1'b1;
    tick();
    chk("ovr_event_wins", err_overrun, 1);
    sending_data = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("ovr_clr", err_overrun, 0);
    idle(2);
    chk("ovr_words", got.size() - b0, 4);
    chk("ovr_busy", busy, 0);

    // Reset during BINS.
    word_ready = 1'b0;
    send_pairs(fbits(vt[1]), 12, 1'b1);
    reset = 1'b1;
    tick();
    chk("mrst_outs", {word_valid, busy, ch_out, ts_valid, frame_done}, 0);
    chk("mrst_ts", ts_out, 0);
    chk("mrst_data", {word_index, word_data}, 0);
    reset = 1'b0;
    word_ready = 1'b1;
    tick();
    b0 = got.size();
    send_pairs(fbits(vt[0]), 20, 1'b0);
    idle(4);
    chk("mrst_next_ts", ts_out, 8'hA5);
    chk("mrst_next_cnt", got.size() - b0, 4);
    chk_words("mrst_next", b0, vt[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
